// File: rtl/mac_chain_pkg.sv
// mac_chain_ctrl shared types: sequencer state encoding and pipeline constants.
// Imported by the controller and its phase counter.
package mac_chain_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_COMPUTE,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } mac_ctrl_state_t;

  localparam int MAC_RD_LATENCY  = 1;
  localparam int MAC_FLUSH_EXTRA = 1;

endpackage

// File: rtl/mac_chain_ctrl_if.sv
// Result handshake bundle between mac_chain_ctrl and its downstream consumer.
// master drives valid/data, slave drives ready.
interface mac_chain_ctrl_if #(
  parameter int DW = 128
);

  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;

  modport master (
    output res_valid,
    output res_data,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    output res_ready
  );

endinterface

// File: rtl/mac_ctrl_phase_cnt.sv
// Phase counter for mac_chain_ctrl: clears on load, counts when enabled,
// flags terminal count when the value equals last.
module mac_ctrl_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

// File: rtl/mac_chain_ctrl.sv
// MAC_chain row sequencer: preload weights, stream activations, flush, hand off.
// Define MAC_CHAIN_CTRL_PERF_EN to add the perf_cycles busy-cycle counter.
module mac_chain_ctrl
  import mac_chain_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int K_W       = 8,
  parameter int WA_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MAC_CHAIN_CTRL_PERF_EN
  output logic [31:0]               perf_cycles,
`endif
  input  logic                      start,
  input  logic [K_W-1:0]            k_len,
  output logic                      busy,
  output logic                      done,
  output logic                      wt_rd_en,
  output logic [WA_W-1:0]           wt_rd_addr,
  input  logic [BIT_WIDTH-1:0]      wt_rdata,
  output logic                      act_rd_en,
  output logic [K_W-1:0]            act_rd_addr,
  input  logic [BIT_WIDTH-1:0]      act_rdata,
  output logic                      chain_control,
  output logic [BIT_WIDTH-1:0]      chain_data,
  output logic [BIT_WIDTH-1:0]      chain_weight,
  input  logic [ACC_WIDTH*SIZE-1:0] chain_acc,
  output logic [ACC_WIDTH*SIZE-1:0] chain_acc_in,
  mac_chain_ctrl_if.master          res_if
);

  localparam int FLUSH_LEN = MAC_RD_LATENCY + (SIZE - 1) + MAC_FLUSH_EXTRA;

  mac_ctrl_state_t state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic wt_flag_q, wt_flag_d;
  logic act_flag_q, act_flag_d;
  logic [ACC_WIDTH*SIZE-1:0] res_data_q, res_data_d;

  logic [K_W-1:0] cnt;
  logic [K_W-1:0] cnt_last;
  logic cnt_tc;
  logic cnt_load;
  logic cnt_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (k_len == '0) ? S_DONE : S_PRELOAD;
      S_PRELOAD: if (cnt_tc) state_d = S_COMPUTE;
      S_COMPUTE: if (cnt_tc) state_d = S_FLUSH;
      S_FLUSH:   if (cnt_tc) state_d = S_DRAIN;
      S_DRAIN:   if (res_if.res_ready) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_last = '0;
    unique case (1'b1)
      state_q == S_PRELOAD: cnt_last = K_W'(SIZE - 1);
      state_q == S_COMPUTE: cnt_last = k_q - K_W'(1);
      state_q == S_FLUSH:   cnt_last = K_W'(FLUSH_LEN - 1);
      default:              cnt_last = '0;
    endcase
  end

  assign cnt_load = (state_d != state_q);
  assign cnt_en   = (state_q == S_PRELOAD) ||
                    (state_q == S_COMPUTE) ||
                    (state_q == S_FLUSH);

  mac_ctrl_phase_cnt #(
    .W (K_W)
  ) u_phase_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .last (cnt_last),
    .cnt  (cnt),
    .tc   (cnt_tc)
  );

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign wt_rd_en    = (state_q == S_PRELOAD);
  assign wt_rd_addr  = wt_rd_en ? cnt[WA_W-1:0] : '0;
  assign act_rd_en   = (state_q == S_COMPUTE);
  assign act_rd_addr = act_rd_en ? cnt : '0;

  // SRAM data arrives one cycle after the read, so the chain follows the
  // delayed read enables; zero data keeps accumulators frozen afterwards.
  assign chain_control = wt_flag_q;
  assign chain_weight  = wt_flag_q ? wt_rdata : '0;
  assign chain_data    = act_flag_q ? act_rdata : '0;
  assign chain_acc_in  = '0;

  assign res_if.res_valid = (state_q == S_DRAIN);
  assign res_if.res_data  = res_data_q;

  always_comb begin
    k_d        = k_q;
    wt_flag_d  = wt_rd_en;
    act_flag_d = act_rd_en;
    res_data_d = res_data_q;
    if (state_q == S_IDLE && start)
      k_d = k_len;
    if (state_q == S_FLUSH && cnt_tc)
      res_data_d = chain_acc;
  end

`ifdef MAC_CHAIN_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start)
      perf_d = '0;
    else if (busy && perf_q != '1)
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      perf_q <= '0;
    else
      perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      wt_flag_q  <= 1'b0;
      act_flag_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wt_flag_q  <= wt_flag_d;
      act_flag_q <= act_flag_d;
      res_data_q <= res_data_d;
    end
  end

endmodule

// File: tb/tb_mac_chain_ctrl.sv
// Bench for mac_chain_ctrl: SRAM and MAC_chain behavioural models, job table
// plus hand sequences for zero length and mid-job reset.
module tb_mac_chain_ctrl;

  localparam int SIZE = 4;
  localparam int BW   = 8;
  localparam int AW   = 32;
  localparam int KW   = 8;
  localparam int WAW  = 2;
  localparam int DW   = AW * SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          wt_rd_en;
  logic [WAW-1:0] wt_rd_addr;
  logic [BW-1:0] wt_rdata = '0;
  logic          act_rd_en;
  logic [KW-1:0] act_rd_addr;
  logic [BW-1:0] act_rdata = '0;
  logic          chain_control;
  logic [BW-1:0] chain_data;
  logic [BW-1:0] chain_weight;
  logic [DW-1:0] chain_acc;
  logic [DW-1:0] chain_acc_in;
`ifdef MAC_CHAIN_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  mac_chain_ctrl_if #(.DW(DW)) res_if ();

  mac_chain_ctrl dut (
    .clk           (clk),
    .rst           (rst),
`ifdef MAC_CHAIN_CTRL_PERF_EN
    .perf_cycles   (perf_cycles),
`endif
    .start         (start),
    .k_len         (k_len),
    .busy          (busy),
    .done          (done),
    .wt_rd_en      (wt_rd_en),
    .wt_rd_addr    (wt_rd_addr),
    .wt_rdata      (wt_rdata),
    .act_rd_en     (act_rd_en),
    .act_rd_addr   (act_rd_addr),
    .act_rdata     (act_rdata),
    .chain_control (chain_control),
    .chain_data    (chain_data),
    .chain_weight  (chain_weight),
    .chain_acc     (chain_acc),
    .chain_acc_in  (chain_acc_in),
    .res_if        (res_if)
  );

  logic [BW-1:0] wt_mem [SIZE];
  logic [BW-1:0] act_mem [256];

  always @(posedge clk) begin
    if (wt_rd_en)  wt_rdata  <= wt_mem[wt_rd_addr];
    if (act_rd_en) act_rdata <= act_mem[act_rd_addr];
  end

  // Golden MAC_chain: weights shift in under control, data hops one MAC per cycle.
  logic [AW-1:0] m_w [SIZE];
  logic [AW-1:0] m_d [SIZE];
  logic [AW-1:0] m_acc [SIZE];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        m_w[i] <= '0; m_d[i] <= '0; m_acc[i] <= '0;
      end
    end else if (chain_control) begin
      m_w[0] <= AW'(chain_weight);
      for (int i = 1; i < SIZE; i++) m_w[i] <= m_w[i-1];
      for (int i = 0; i < SIZE; i++) begin
        m_d[i] <= '0; m_acc[i] <= '0;
      end
    end else begin
      m_acc[0] <= m_acc[0] + AW'(chain_data) * m_w[0];
      m_d[0]   <= AW'(chain_data);
      for (int i = 1; i < SIZE; i++) begin
        m_acc[i] <= m_acc[i] + m_d[i-1] * m_w[i];
        m_d[i]   <= m_d[i-1];
      end
    end
  end

  assign chain_acc = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run_job(input int k, input int dly, input int pulse_at,
                         input logic [DW-1:0] exp, input string tag);
    int vcnt = 0, vcyc = -1, dcyc = -1, wcnt = 0, acnt = 0;
    int aerr = 0, serr = 0, ctl_first = -1;
    logic [DW-1:0] d0 = '0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    res_if.res_ready = 1'b0;
    @(posedge clk);
    for (int n = 1; n < 100 && dcyc < 0; n++) begin
      @(negedge clk);
      start = (n == pulse_at);
      if (n == pulse_at) k_len = 8'd9;
      if (chain_control && ctl_first < 0) ctl_first = n;
      if (wt_rd_en) wcnt++;
      if (act_rd_en) begin
        if (int'(act_rd_addr) != acnt) aerr++;
        acnt++;
      end
      if (res_if.res_valid) begin
        if (vcnt == 0) begin
          vcyc = n;
          d0 = res_if.res_data;
        end else if (res_if.res_data !== d0) serr++;
        vcnt++;
        res_if.res_ready = (vcnt > dly);
      end
      if (done) dcyc = n;
    end
    start = 1'b0;
    res_if.res_ready = 1'b0;
    chki({tag, "_ctl_first"}, ctl_first, 2);
    chki({tag, "_wt_reads"}, wcnt, SIZE);
    chki({tag, "_act_reads"}, acnt, k);
    chki({tag, "_act_addr_seq"}, aerr, 0);
    chki({tag, "_valid_lat"}, vcyc, 2 * SIZE + k + 2);
    chki({tag, "_valid_cycles"}, vcnt, dly + 1);
    chki({tag, "_data_stable"}, serr, 0);
    chk({tag, "_res_data"}, d0, exp);
    chki({tag, "_done_lat"}, dcyc, 2 * SIZE + k + 3 + dly);
    @(negedge clk);
    chki({tag, "_done_pulse"}, int'(done), 0);
    chki({tag, "_idle_after"}, int'(busy), 0);
  endtask

  typedef struct {
    int            k;
    int            dly;
    int            pulse;
    logic [DW-1:0] exp;
    string         tag;
  } vec_t;

  vec_t vt [5];
  int   seen;

  initial begin
    vt[0] = '{3, 0, 0, {32'd18, 32'd36, 32'd54, 32'd72}, "basic"};
    vt[1] = '{1, 0, 0, {32'd5, 32'd10, 32'd15, 32'd20}, "k1"};
    vt[2] = '{5, 2, 7, {32'd35, 32'd70, 32'd105, 32'd140}, "busy_start"};
    vt[3] = '{2, 5, 0, {32'd11, 32'd22, 32'd33, 32'd44}, "backpressure"};
    vt[4] = '{3, 2, 0, {32'd18, 32'd36, 32'd54, 32'd72}, "ready_dly2"};

    wt_mem = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 256; i++) act_mem[i] = BW'(5 + i);

    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    res_if.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chki("rst_busy_done", int'({busy, done}), 0);
    chki("rst_reads", int'({wt_rd_en, act_rd_en, wt_rd_addr, act_rd_addr}), 0);
    chki("rst_chain", int'({chain_control, chain_data, chain_weight}), 0);
    chki("rst_valid", int'(res_if.res_valid), 0);
    chk("rst_res_data", res_if.res_data, '0);
    chk("acc_in_zero", chain_acc_in, '0);
`ifdef MAC_CHAIN_CTRL_PERF_EN
    chki("rst_perf", int'(perf_cycles), 0);
`endif

    foreach (vt[i]) run_job(vt[i].k, vt[i].dly, vt[i].pulse, vt[i].exp, vt[i].tag);

`ifdef MAC_CHAIN_CTRL_PERF_EN
    chki("perf_cycles", int'(perf_cycles), 16);
    @(negedge clk);
    chki("perf_hold", int'(perf_cycles), 16);
`endif

    // Zero-length job goes straight to DONE without any reads.
    @(negedge clk);
    start = 1'b1;
    k_len = '0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chki("zl_done", int'(done), 1);
    chki("zl_busy", int'(busy), 1);
    seen = int'(wt_rd_en | act_rd_en | res_if.res_valid);
    @(negedge clk);
    chki("zl_done_once", int'(done), 0);
    repeat (3) begin
      seen += int'(wt_rd_en | act_rd_en | res_if.res_valid);
      @(negedge clk);
    end
    chki("zl_no_activity", seen, 0);

    // Reset while in FLUSH, then a fresh job.
    start = 1'b1;
    k_len = 8'd3;
    @(posedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chki("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chki("mid_rst_busy_done", int'({busy, done}), 0);
    chki("mid_rst_ctrl", int'({chain_control, wt_rd_en, act_rd_en}), 0);
    chki("mid_rst_valid", int'(res_if.res_valid), 0);
    chk("mid_rst_res_data", res_if.res_data, '0);
    run_job(2, 0, 0, {32'd11, 32'd22, 32'd33, 32'd44}, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_chain_ctrl.md
# mac_chain_ctrl

Sequencer for one MAC_chain row. On `start` it preloads `SIZE` weights into the chain with `control` high, then streams `k_len` activations with `control` low and flushes the pipeline. It then captures the packed accumulator vector and hands it downstream over a valid/ready handshake. It sits between the row's weight/activation SRAMs (1-cycle read latency) and the MAC_chain instance.

## Interface
- `SIZE`, 4: MACs in the chain.
- `BIT_WIDTH`, 8: data/weight width.
- `ACC_WIDTH`, 32: per-MAC accumulator width (`acc_width_next` of the chain).
- `K_W`, 8: width of `k_len`; also activation address width.
- `WA_W`, 2: weight address width, equal to clog2(`SIZE`).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `k_len` in `K_W`: reduction length; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job end.
- `wt_rd_en` out 1: weight SRAM read enable.
- `wt_rd_addr` out `WA_W`: weight SRAM address.
- `wt_rdata` in `BIT_WIDTH`: weight SRAM data, valid one cycle after `wt_rd_en`.
- `act_rd_en` out 1: activation SRAM read enable.
- `act_rd_addr` out `K_W`: activation SRAM address.
- `act_rdata` in `BIT_WIDTH`: activation SRAM data, valid one cycle after `act_rd_en`.
- `chain_control` out 1: drives MAC_chain `control`. High loads weights and clears accumulators.
- `chain_data` out `BIT_WIDTH`: drives MAC_chain `data`.
- `chain_weight` out `BIT_WIDTH`: drives MAC_chain `weight`.
- `chain_acc` in `ACC_WIDTH*SIZE`: MAC_chain `acc_out`.
- `chain_acc_in` out `ACC_WIDTH*SIZE`: MAC_chain `acc_in`, tied to 0.
- `res_valid` out 1: result available.
- `res_data` out `ACC_WIDTH*SIZE`: latched accumulator vector.
- `res_ready` in 1: downstream accepts.

## Operation
- **States:** IDLE, PRELOAD, COMPUTE, FLUSH, DRAIN, DONE.
- **IDLE**
  - `start`=1 and `k_len`>0: latch `k_len`, go to PRELOAD.
  - `start`=1 and `k_len`=0: go directly to DONE. No reads are issued and `res_valid` is never asserted.
  - `start` outside IDLE is ignored.
- **PRELOAD:** `SIZE` cycles. `wt_rd_en`=1 with `wt_rd_addr` = 0..`SIZE`-1, then go to COMPUTE.
- **COMPUTE:** `k_len` cycles. `act_rd_en`=1 with `act_rd_addr` = 0..`k_len`-1, then go to FLUSH.
- **FLUSH:** `SIZE`+1 cycles with no reads. This covers the read latency plus `SIZE`-1 hops of data propagation. Then go to DRAIN and latch `chain_acc` into `res_data`.
- **DRAIN:** `res_valid`=1 with `res_data` held stable. When `res_valid` and `res_ready` are both high, go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Chain drive**, registered phase flags delayed one cycle from read issue:
  - `chain_control` = delayed `wt_rd_en`.
  - `chain_weight` = `wt_rdata` when that flag is high, else 0.
  - `chain_data` = `act_rdata` when delayed `act_rd_en` is high, else 0.
  - Zero data outside compute means the accumulators hold their value through FLUSH and DRAIN.
- **Counters:**
  - Phase counter is `K_W` bits and resets to 0 on every state entry.
  - Address equals the counter value.
  - No wrap-around is possible because `k_len` is at most 2^`K_W`-1.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `res_data`, the phase flags and the counters.
- **`rst` mid-job:** return to IDLE on the next edge. Any in-flight result is discarded. `chain_control` is 0 from the next cycle.
- **`start` latency:** `start` sampled at edge t0 → PRELOAD occupies cycles t0+1..t0+`SIZE`.
- **First chain weight:** appears at t0+2.
- **`res_valid` latency:** first asserted at t0 + 2·`SIZE` + `k_len` + 2.
- **Handshake:**
  - `res_valid` stays high until the handshake completes.
  - `res_data` must not change while `res_valid` is high.
  - The `done` pulse comes in the cycle after the handshake edge.
- **`res_ready` held high:** DRAIN lasts exactly one cycle.
- **Back-to-back jobs:** `start` may be asserted in the cycle after `done`. The IDLE dwell is at least 1 cycle.

## Configuration
- **`MAC_CHAIN_CTRL_PERF_EN` defined:**
  - Adds output `perf_cycles` [31:0].
  - Counts cycles with `busy`=1, saturating at 2^32-1.
  - Clears on accepted `start` and on `rst`.
  - Holds its value after `done` until the next `start`.
- **Undefined:** the port and the counter are absent, with no other behaviour change.

## Structure
- **Package `mac_chain_pkg`:** state enum `mac_ctrl_state_t`, plus the constants `MAC_RD_LATENCY`=1 and `MAC_FLUSH_EXTRA`=1.
- **One sub-module:** `mac_ctrl_phase_cnt`, a loadable counter with a terminal-count flag, reused for PRELOAD, COMPUTE and FLUSH.

## Test plan
- **Basic job:** `SIZE`=4, `k_len`=3, weights 1,2,3,4, activations 5,6,7, `res_ready`=1.
  - `res_valid` at t0+13.
  - `res_data` matches the golden MAC_chain model.
  - `done` at t0+14.
- **Backpressure:** `res_ready` low for 5 cycles in DRAIN → `res_valid` and `res_data` stable for all 5 cycles, and a single `done` after ready rises.
- **Zero length:** `k_len`=0 → `done` at t0+1; `wt_rd_en`, `act_rd_en` and `res_valid` never high.
- **Start while busy:** `start` pulsed during COMPUTE → ignored; `act_rd_addr` sequence continues uninterrupted.
- **Reset mid-job:** `rst` asserted in FLUSH → next cycle IDLE with all outputs 0; a new job then completes correctly.
- **Perf counter** (`MAC_CHAIN_CTRL_PERF_EN`): the basic job with a 2-cycle ready delay → `perf_cycles`=16.
